// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder and its storage array.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_LATENCY = 3;
  localparam int DEF_DEPTH   = 256;
  localparam int WORD_BYTES  = 4;
  localparam int OFS_W       = $clog2(WORD_BYTES);

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage: synchronous write, combinational read, contents never reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = 32,
  parameter int AW     = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder with fixed request-to-response latency.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int                AW       = idx_width(DEPTH);
  localparam logic [31-OFS_W:0] DEPTH_W  = (32-OFS_W)'(DEPTH);
  localparam logic [3:0]        CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, enter_resp;
  logic        err_in;
  logic        we_p0, err_p0;
  logic [AW-1:0] idx_p0;
  logic [31:0] wdata_p0;
  logic        we_sel, err_sel;
  logic [AW-1:0] idx_sel;
  logic [31:0] wdata_sel, rd_word;

  assign ready_o     = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign accept      = req_i & ready_o;
  assign err_in      = (addr_i[OFS_W-1:0] != '0) || (addr_i[31:OFS_W] >= DEPTH_W);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Down-counter saturates at zero once WAIT is left.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                        cnt <= 4'd0;
    else if (accept && (LATENCY > 1))    cnt <= CNT_LOAD;
    else if (state == WAIT)              cnt <= (cnt > 4'd1) ? cnt - 4'd1 : 4'd0;
  end

  // Request capture stage
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_p0    <= we_i;
      err_p0   <= err_in;
      idx_p0   <= addr_i[OFS_W+AW-1:OFS_W];
      wdata_p0 <= wdata_i;
    end
  end

  // A one-cycle latency commits on the accept edge itself, before capture settles.
  always_comb begin
    if (state == IDLE) begin
      we_sel    = we_i;
      err_sel   = err_in;
      idx_sel   = addr_i[OFS_W+AW-1:OFS_W];
      wdata_sel = wdata_i;
    end else begin
      we_sel    = we_p0;
      err_sel   = err_p0;
      idx_sel   = idx_p0;
      wdata_sel = wdata_p0;
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .AW     (AW)
  ) u_array (
    .clk   (clk_i),
    .we    (enter_resp & we_sel & ~err_sel),
    .waddr (idx_sel),
    .wdata (wdata_sel),
    .raddr (idx_sel),
    .rdata (rd_word)
  );

  // Response stage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else if (enter_resp) begin
      rdata_o <= (we_sel || err_sel) ? 32'd0 : rd_word;
      err_o   <= err_sel;
    end
  end

endmodule
